mining_controller: RTL
======================

Name: mining_controller

Overview:
Sequences the proof-of-work miner (mine_block) for the two-player coin ledger. Accepts transaction requests from player 1 and player 2 over a req/ack handshake and arbitrates between them round-robin. Checks the payer balance, runs the miner with the current chain tip, and on success commits the new block hash, updates both balances and reports completion. Sits between the player input logic and the verification datapath.

Parameters:
INIT_BALANCE, 8'd100, balance loaded into both players at reset
GENESIS_HASH, 8'h00, chain tip at reset
CLEAR_CYCLES, 2, cycles the miner is held in its synchronous reset before each job (range 1..7)
MAX_MINE_CYCLES, 20'hFFFFF, mining-cycle budget before abort

Ports:
clock  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
req_p1  in  1  player 1 request (level)
sig_p1  in  8  player 1 signature
amt_p1  in  8  player 1 amount (P1 pays P2)
req_p2  in  1  player 2 request (level)
sig_p2  in  8  player 2 signature
amt_p2  in  8  player 2 amount (P2 pays P1)
ack_p1  out  1  one-cycle completion pulse to player 1
ack_p2  out  1  one-cycle completion pulse to player 2
status  out  2  result, valid while an ack is high: 00 accepted, 01 insufficient balance, 10 timeout, 11 zero amount
miner_resetn  out  1  to mine_block resetn (synchronous active-low on the miner side)
miner_enable  out  1  to mine_block enable
previous_hash  out  8  to mine_block previous_hash (chain tip)
signature  out  8  to mine_block signature
amount  out  8  to mine_block amount
transaction_direction  out  1  to mine_block; 0 = P1 pays P2, 1 = P2 pays P1
done_mining  in  1  from mine_block
new_hash  in  8  from mine_block
block_valid  out  1  one-cycle pulse when a block commits
block_hash  out  8  last committed hash
block_index  out  8  count of committed blocks, wraps 255->0
balance_p1  out  8  player 1 balance
balance_p2  out  8  player 2 balance
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE; all acks, status, miner_enable, block_valid, busy = 0.
  - miner_resetn=0, so the miner is held in reset.
  - previous_hash=block_hash=GENESIS_HASH; block_index=0; balances=INIT_BALANCE.
  - signature/amount/direction=0; last_grant=P2.
- In IDLE, miner_resetn stays 0.
- FSM states: IDLE, CLEAR, MINE, COMMIT, ACK.
- IDLE: sample req_p1/req_p2 each cycle.
  - One request high: grant it. Both high: grant the requester other than last_grant. last_grant updates on every grant.
  - On grant: latch signature, amount and direction into the miner-facing outputs. These stay stable until the job returns to IDLE.
  - Validity check uses the latched amount and the payer balance:
    - amount==0 -> ACK with status 11.
    - amount > payer balance -> ACK with status 01.
    - Otherwise -> CLEAR.
  - Rejected requests never touch the miner, balances or chain.
- CLEAR: miner_resetn=0, miner_enable=0 for exactly CLEAR_CYCLES cycles. done_mining is ignored. Then -> MINE.
- MINE: miner_resetn=1, miner_enable=1. A 20-bit cycle counter starts at 1 on the first MINE cycle.
  - done_mining=1 -> COMMIT; the miner's new_hash is latched in this same cycle.
  - If the counter reaches MAX_MINE_CYCLES with done_mining=0 -> ACK with status 10. No chain or balance change.
  - If done_mining and the limit coincide, done_mining wins (commit).
- COMMIT: single cycle.
  - block_valid=1; block_hash and previous_hash <= latched new_hash; block_index increments.
  - Payer balance -= amount (never underflows, already checked).
  - Payee balance += amount, saturating at 255.
  - miner_enable=0. -> ACK with status 00.
- ACK: single cycle. The ack of the granted player is 1 with status valid, then -> IDLE.
  - The requester must drop req the cycle after ack. A req still high in IDLE is treated as a new request.
- Latency, request sampled at cycle t:
  - Rejected: ack at t+1.
  - Accepted: CLEAR at t+1..t+CLEAR_CYCLES, MINE from t+CLEAR_CYCLES+1. done_mining first seen at cycle m -> block_valid at m+1, ack at m+2, IDLE at m+3.
  - Timeout: ack on the cycle after the limit.
- Requests arriving while busy are held by the requester (level), not queued.
- Async reset mid-job aborts it: no ack, no commit, and miner_resetn goes to 0 immediately.

Test Plan:
- Reset: balances 100/100, block_hash 00, block_index 0, miner_resetn 0, busy 0 -> all hold until the first request.
- P1 req amt=30: miner_resetn low 2 cycles; miner model raises done_mining with new_hash=8'h0A after 5 MINE cycles -> block_valid 1 cycle later, block_hash=0A, previous_hash=0A, balances 70/130, ack_p1 with status 00, direction=0.
- Simultaneous req_p1/req_p2 after reset -> P1 granted first, P2 granted on the next IDLE visit; two commits leave block_index=2.
- P2 req amt=200 with balance 130 -> ack_p2 at t+1 with status 01, miner_resetn stays 0, no block_valid. Separately, amt=0 -> status 11.
- MAX_MINE_CYCLES=16, done_mining never asserted -> ack with status 10 after 16 MINE cycles; balances and block_hash unchanged.
- Payee at 250 receives 10 -> saturates at 255. resetn pulsed during MINE -> all reset values restored, no ack issued.

Source files
------------

// File: rtl/mining_controller.sv
// mining_controller: round-robin arbiter for two players' transactions that runs a proof-of-work miner job for each accepted one
// and commits the resulting block to the chain and the balances.
module mining_controller #(
  parameter logic [7:0]  INIT_BALANCE    = 8'd100,
  parameter logic [7:0]  GENESIS_HASH    = 8'h00,
  parameter int unsigned CLEAR_CYCLES    = 2,
  parameter logic [19:0] MAX_MINE_CYCLES = 20'hFFFFF
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       req_p1,
  input  logic [7:0] sig_p1,
  input  logic [7:0] amt_p1,
  input  logic       req_p2,
  input  logic [7:0] sig_p2,
  input  logic [7:0] amt_p2,
  output logic       ack_p1,
  output logic       ack_p2,
  output logic [1:0] status,
  output logic       miner_resetn,
  output logic       miner_enable,
  output logic [7:0] previous_hash,
  output logic [7:0] signature,
  output logic [7:0] amount,
  output logic       transaction_direction,
  input  logic       done_mining,
  input  logic [7:0] new_hash,
  output logic       block_valid,
  output logic [7:0] block_hash,
  output logic [7:0] block_index,
  output logic [7:0] balance_p1,
  output logic [7:0] balance_p2,
  output logic       busy
);
  typedef enum logic [2:0] {IDLE, CLEAR, MINE, COMMIT, ACK} state_t;
  state_t state, next_state;
  logic        last_grant, grant, grant_p2, reject, clear_done, timeout;
  logic [2:0]  clear_cnt;
  logic [19:0] mine_cnt;
  logic [7:0]  hash_q, tip, req_amt, payer_bal, payer_new, payee_new;
  logic [8:0]  payee_sum;
  logic [1:0]  status_q;
  // When both players request, the one not served last wins
  assign grant      = req_p1 | req_p2;
  assign grant_p2   = req_p2 & (~req_p1 | ~last_grant);
  assign req_amt    = grant_p2 ? amt_p2 : amt_p1;
  assign payer_bal  = grant_p2 ? balance_p2 : balance_p1;
  assign reject     = req_amt == 8'd0 || req_amt > payer_bal;
  assign clear_done = clear_cnt == 3'(CLEAR_CYCLES);
  assign timeout    = mine_cnt == MAX_MINE_CYCLES;
  assign payer_new  = (transaction_direction ? balance_p2 : balance_p1) - amount;
  assign payee_sum  = {1'b0, transaction_direction ? balance_p1 : balance_p2} + {1'b0, amount};
  assign payee_new  = payee_sum[8] ? 8'hFF : payee_sum[7:0];
  assign previous_hash = tip;
  assign block_hash    = tip;
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= next_state;
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = grant ? (reject ? ACK : CLEAR) : IDLE;
      CLEAR:   next_state = clear_done ? MINE : CLEAR;
      MINE:    next_state = done_mining ? COMMIT : timeout ? ACK : MINE;
      COMMIT:  next_state = ACK;
      default: next_state = IDLE;
    endcase
  end
  always_comb begin
    busy         = state != IDLE;
    miner_resetn = state == MINE;
    miner_enable = state == MINE;
    block_valid  = state == COMMIT;
    ack_p1       = state == ACK && !transaction_direction;
    ack_p2       = state == ACK && transaction_direction;
    status       = state == ACK ? status_q : 2'b00;
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      last_grant            <= 1'b1;
      transaction_direction <= 1'b0;
      signature             <= 8'h00;
      amount                <= 8'h00;
      status_q              <= 2'b00;
      clear_cnt             <= 3'd0;
      mine_cnt              <= 20'd0;
      hash_q                <= GENESIS_HASH;
      tip                   <= GENESIS_HASH;
      block_index           <= 8'd0;
      balance_p1            <= INIT_BALANCE;
      balance_p2            <= INIT_BALANCE;
    end else begin
      case (state)
        IDLE: if (grant) begin
          last_grant            <= grant_p2;
          transaction_direction <= grant_p2;
          signature             <= grant_p2 ? sig_p2 : sig_p1;
          amount                <= req_amt;
          status_q              <= req_amt == 8'd0 ? 2'b11 : req_amt > payer_bal ? 2'b01 : 2'b00;
          clear_cnt             <= 3'd1;
        end
        CLEAR: begin
          clear_cnt <= clear_cnt + 3'd1;
          mine_cnt  <= 20'd1;
        end
        MINE: begin
          mine_cnt <= mine_cnt + 20'd1;
          if (done_mining) hash_q <= new_hash;
          else if (timeout) status_q <= 2'b10;
        end
        COMMIT: begin
          tip         <= hash_q;
          block_index <= block_index + 8'd1;
          balance_p1  <= transaction_direction ? payee_new : payer_new;
          balance_p2  <= transaction_direction ? payer_new : payee_new;
        end
        default: ;
      endcase
    end
  end
endmodule
